// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline register chain.
// Sizes the occupancy counter so it can hold every value from 0 to DEPTH.
package pipe_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    // Bits needed to count 0..depth inclusive, never narrower than one bit.
    function automatic int unsigned occ_width(input int unsigned depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: a valid bit plus a data register.
// Data is only captured alongside a valid word, so bubbles never toggle it.
module pipe_reg_stage #(
    parameter int unsigned         WIDTH   = 8,
    parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             vld_d_i,
    input  logic [WIDTH-1:0] dat_d_i,
    output logic             vld_q_o,
    output logic [WIDTH-1:0] dat_q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q_o <= 1'b0;
            dat_q_o <= RST_VAL;
        end else if (clr_i) begin
            vld_q_o <= 1'b0;
            dat_q_o <= RST_VAL;
        end else if (load_i) begin
            vld_q_o <= vld_d_i;
            if (vld_d_i) begin
                dat_q_o <= dat_d_i;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sclr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(DEPTH)-1:0]    occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_vld;
    logic [WIDTH-1:0] dat_q   [DEPTH];
    logic [WIDTH-1:0] src_dat [DEPTH];
    logic             rdy_acc;
    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Ready chain unrolled from the output side: a stage is ready if it or any
    // stage downstream of it is empty, or the consumer is taking the last word.
    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            rdy_acc             = rdy_acc | !vld_q[DEPTH-1-j];
            rdy[DEPTH-1-j]      = rdy_acc;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_vld[k] = in_valid;
            assign src_dat[k] = in_data;
        end else begin : g_body
            assign src_vld[k] = vld_q[k-1];
            assign src_dat[k] = dat_q[k-1];
        end

        pipe_reg_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (sclr),
            .load_i  (rdy[k]),
            .vld_d_i (src_vld[k]),
            .dat_d_i (src_dat[k]),
            .vld_q_o (vld_q[k]),
            .dat_q_o (dat_q[k])
        );
    end

    assign in_ready  = rdy[0] & !sclr;
    assign out_valid = vld_q[DEPTH-1] & !sclr;
    assign out_data  = dat_q[DEPTH-1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (sclr) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
